irq_pending_dispatch: RTL and testbench

- Upstream and downstream companion of the 8-input priority encoder (inputs a[7:0]; outputs y[2:0], NONE).
- Captures rising edges on 8 request lines into a sticky pending register and drives the masked pending vector into the encoder.
- Takes the encoder's index back and offers it to a consumer over a valid/ready handshake.
- Clears the served bit on acceptance, or on timeout.

---
 rtl/irq_pending_dispatch_if.sv | 12 +
 rtl/irq_pending_dispatch.sv | 116 +++++++++++
 tb/tb_irq_pending_dispatch.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/irq_pending_dispatch_if.sv
// Consumer-side offer handshake of irq_pending_dispatch.
//   irq_valid : offer valid (dispatcher -> consumer)
//   irq_id    : offered index, stable while irq_valid = 1
//   irq_ready : consumer accepts when irq_valid & irq_ready
interface irq_pending_dispatch_if;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ready;

  modport master (output irq_valid, output irq_id, input irq_ready);
  modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/irq_pending_dispatch.sv
// Pending-interrupt capture and dispatch around an external 8-input priority
// encoder. Rising edges on req set sticky pending bits; the masked pending
// vector drives the encoder, and the encoder's index is offered to a consumer
// over a valid/ready handshake. The served bit clears on accept or timeout.
//   clk, reset : clock, synchronous active-high reset
//   req        : level request lines (0->1 sets the pending bit)
//   mask       : per-bit enable, 1 = may be offered
//   pend       : pend_r & mask, to encoder a[7:0]
//   enc_y      : encoder index of highest set bit of pend
//   enc_none   : encoder says pend == 0
//   irq        : offer handshake (master side)
//   dropped    : one-cycle pulse when an offer times out
//   pend_raw   : unmasked pending register
module irq_pending_dispatch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] pend,
  input  logic [2:0] enc_y,
  input  logic       enc_none,
  output logic       dropped,
  output logic [7:0] pend_raw,
  irq_pending_dispatch_if.master irq
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

  typedef enum logic {IDLE, OFFER} state_e;

  state_e        state_q, state_d;
  logic [7:0]    req_q, req_d;
  logic [7:0]    pend_q, pend_d;
  logic [2:0]    irq_id_q, irq_id_d;
  logic          irq_valid_q, irq_valid_d;
  logic          dropped_q, dropped_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] rise, clr;
  logic       hs, tmo;

  always_comb begin
    req_d = req;
    rise  = req & ~req_q;
    hs    = (state_q == OFFER) && irq.irq_ready;
    // handshake wins over timeout in the final cycle
    tmo   = (state_q == OFFER) && !irq.irq_ready && (TIMEOUT != 0) &&
            (cnt_q == CNT_LAST);
    clr   = (hs || tmo) ? (8'b1 << irq_id_q) : 8'b0;
    // set wins over clear for the same bit
    pend_d = (pend_q & ~clr) | rise;

    state_d     = state_q;
    irq_id_d    = irq_id_q;
    irq_valid_d = irq_valid_q;
    dropped_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        irq_valid_d = 1'b0;
        if (!enc_none) begin
          irq_id_d    = enc_y;
          irq_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (tmo) begin
          irq_valid_d = 1'b0;
          dropped_d   = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q != '1) begin
          // saturate rather than wrap (only reachable with TIMEOUT = 0)
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pend_q      <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
      dropped_q   <= dropped_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pend          = pend_q & mask;
  assign pend_raw      = pend_q;
  assign dropped       = dropped_q;
  assign irq.irq_valid = irq_valid_q;
  assign irq.irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_pending_dispatch.sv
module tb_irq_pending_dispatch;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req, mask, pend, pend_raw;
  logic [2:0] enc_y;
  logic       enc_none, dropped, rdy;

  irq_pending_dispatch_if irq_if();
  assign irq_if.irq_ready = rdy;

  irq_pending_dispatch #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .mask(mask), .pend(pend),
    .enc_y(enc_y), .enc_none(enc_none), .dropped(dropped),
    .pend_raw(pend_raw), .irq(irq_if)
  );

  always #5 clk = ~clk;

  function automatic int top_bit(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // bench-side priority encoder
  always_comb begin
    enc_none = (pend == 8'h00);
    enc_y    = enc_none ? 3'd0 : 3'(top_bit(pend));
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model: one outstanding offer, its age, and the pending set
  logic [7:0] m_pend, m_prev;
  logic       m_busy, m_drop;
  int         m_id, m_age;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] clr;
    if (reset) begin
      m_pend = 0; m_prev = 0; m_busy = 0; m_drop = 0; m_id = 0; m_age = 0;
      return;
    end
    clr    = 0;
    m_drop = 0;
    if (!m_busy) begin
      if ((m_pend & mask) != 0) begin
        m_id = top_bit(m_pend & mask); m_busy = 1; m_age = 0;
      end
    end else if (rdy) begin
      clr[m_id] = 1'b1; m_busy = 0;
    end else if (m_age == TMO - 1) begin
      clr[m_id] = 1'b1; m_busy = 0; m_drop = 1;
    end else begin
      m_age++;
    end
    m_pend = (m_pend & ~clr) | (req & ~m_prev);
    m_prev = req;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_pend_raw", pend_raw, m_pend);
    chk("m_pend", pend, m_pend & mask);
    chk("m_valid", {7'd0, irq_if.irq_valid}, {7'd0, m_busy});
    chk("m_id", {5'd0, irq_if.irq_id}, 8'(m_id));
    chk("m_dropped", {7'd0, dropped}, {7'd0, m_drop});
  endtask

  task automatic offer(input string tag, input logic v, input int id);
    chk({tag, "_valid"}, {7'd0, irq_if.irq_valid}, {7'd0, v});
    if (v) chk({tag, "_id"}, {5'd0, irq_if.irq_id}, 8'(id));
  endtask

  initial begin
    reset = 1; req = 0; mask = 8'hFF; rdy = 0;
    tick(); tick();
    reset = 0;
    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_pend", pend, 8'h00);
      offer("rst", 1'b0, 0);
      chk("rst_drop", {7'd0, dropped}, 8'd0);
    end

    // two bits, priority order, one bubble between offers
    rdy = 1; req = 8'h24;
    tick(); chk("two_pend0", pend, 8'h24); offer("two_e0", 1'b0, 0);
    tick(); offer("two_e1", 1'b1, 5);
    tick(); offer("two_e2", 1'b0, 0); chk("two_pend2", pend, 8'h04);
    tick(); offer("two_e3", 1'b1, 2);
    tick(); offer("two_e4", 1'b0, 0); chk("two_pend4", pend, 8'h00);
    req = 0; tick(); tick();

    // masked bit waits until unmasked
    mask = 8'h7F; req = 8'h81;
    tick(); chk("msk_raw0", pend_raw, 8'h81);
    tick(); offer("msk_e1", 1'b1, 0);
    tick(); chk("msk_raw2", pend_raw, 8'h80); chk("msk_pend2", pend, 8'h00);
    tick(); tick(); offer("msk_quiet", 1'b0, 0);
    mask = 8'hFF;
    tick(); offer("msk_unmask", 1'b1, 7);
    tick(); offer("msk_acc", 1'b0, 0);
    req = 0; rdy = 0; tick();

    // timeout: exactly TMO cycles of valid, then a drop pulse
    req = 8'h40;
    tick(); chk("to_pend", pend, 8'h40);
    for (int i = 0; i < TMO; i++) begin
      tick(); offer("to_hold", 1'b1, 6); chk("to_nodrop", {7'd0, dropped}, 8'd0);
    end
    tick(); offer("to_end", 1'b0, 0); chk("to_drop", {7'd0, dropped}, 8'd1);
    chk("to_raw", pend_raw, 8'h00);
    tick(); chk("to_drop_pulse", {7'd0, dropped}, 8'd0);

    // handshake in the final cycle beats the timeout
    req = 0; tick();
    req = 8'h40; tick();
    for (int i = 0; i < TMO; i++) begin
      tick(); offer("tw_hold", 1'b1, 6);
    end
    rdy = 1;
    tick(); offer("tw_end", 1'b0, 0); chk("tw_drop", {7'd0, dropped}, 8'd0);
    chk("tw_raw", pend_raw, 8'h00);
    req = 0; tick();

    // re-rise on the accept cycle keeps the bit pending
    req = 8'h08; tick(); chk("rr_pend0", pend, 8'h08);
    req = 8'h00; tick(); offer("rr_e1", 1'b1, 3);
    req = 8'h08; tick(); offer("rr_e2", 1'b0, 0); chk("rr_raw", pend_raw, 8'h08);
    tick(); offer("rr_e3", 1'b1, 3);
    tick(); offer("rr_e4", 1'b0, 0); chk("rr_raw4", pend_raw, 8'h00);
    req = 0; rdy = 0; tick();

    // reset mid-offer with req held high
    req = 8'h10; tick(); tick(); offer("rs_pre", 1'b1, 4);
    reset = 1; tick();
    offer("rs_valid", 1'b0, 0); chk("rs_id", {5'd0, irq_if.irq_id}, 8'd0);
    chk("rs_raw", pend_raw, 8'h00); chk("rs_drop", {7'd0, dropped}, 8'd0);
    reset = 0;
    tick(); chk("rs_cap", pend_raw, 8'h10); offer("rs_e1", 1'b0, 0);
    tick(); offer("rs_e2", 1'b1, 4);
    rdy = 1;
    tick(); tick(); tick();
    chk("rs_nocap", pend_raw, 8'h00); offer("rs_quiet", 1'b0, 0);
    req = 0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      req   = 8'($urandom) & 8'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rdy   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
